seq_gen_prog: RTL

Programmable, parametrised sequence generator. It holds a DEPTH-entry table of WIDTH-bit values, which is writable at runtime, and steps through entries 0..last_idx in one of four modes: up, down, ping-pong or hold. Each enabled cycle emits one registered value, with a valid flag and an end-of-pass pulse. It is the general-purpose replacement for fixed hard-coded value-sequence FSMs such as prime or pattern generators, and feeds pattern and stimulus consumers in the datapath.

---
 rtl/seq_gen_prog.sv | 122 ++++++++++++
 1 files changed

// File: rtl/seq_gen_prog.sv
// Programmable sequence generator: a runtime-writable DEPTH-entry table stepped
// in up, down, ping-pong or hold order, one registered value per enabled cycle.
module seq_gen_prog #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [AW-1:0]    last_idx,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] y,
  output logic             y_valid,
  output logic [AW-1:0]    y_idx,
  output logic             wrap
);

  typedef enum logic {DIR_UP = 1'b0, DIR_DN = 1'b1} dir_t;

  localparam logic [AW-1:0] ONE      = AW'(1);
  localparam logic [AW-1:0] LAST_MAX = AW'(DEPTH - 1);

  logic [WIDTH-1:0] r_table [DEPTH];
  logic [AW-1:0]    r_ptr;
  dir_t             r_dir;
  logic [WIDTH-1:0] r_y;
  logic [AW-1:0]    r_y_idx;
  logic             r_y_valid;
  logic             r_wrap;

  logic [AW-1:0]    w_last;
  logic [AW-1:0]    w_ptr_nxt;
  dir_t             w_dir_nxt;
  logic             w_wrap_nxt;

  always_comb begin
    w_last     = (int'(last_idx) >= DEPTH) ? LAST_MAX : last_idx;
    w_ptr_nxt  = r_ptr;
    w_dir_nxt  = r_dir;
    w_wrap_nxt = 1'b0;
    unique case (mode)
      2'b00: begin
        w_dir_nxt  = DIR_UP;
        w_wrap_nxt = (r_ptr >= w_last);
        w_ptr_nxt  = (r_ptr >= w_last) ? '0 : r_ptr + ONE;
      end
      2'b01: begin
        w_dir_nxt  = DIR_DN;
        w_wrap_nxt = (r_ptr == '0);
        w_ptr_nxt  = ((r_ptr == '0) || (r_ptr > w_last)) ? w_last : r_ptr - ONE;
      end
      2'b10: begin
        if (r_dir == DIR_UP) begin
          if (r_ptr >= w_last) begin
            w_dir_nxt = DIR_DN;
            w_ptr_nxt = (w_last == '0) ? '0 : w_last - ONE;
          end else begin
            w_ptr_nxt = r_ptr + ONE;
          end
        end else begin
          // A single-entry range never completes a period, so no wrap there.
          w_wrap_nxt = (r_ptr == '0) && (w_last != '0);
          if (r_ptr == '0) begin
            w_dir_nxt = DIR_UP;
            w_ptr_nxt = (w_last == '0) ? '0 : ONE;
          end else if (r_ptr > w_last) begin
            w_ptr_nxt = w_last;
          end else begin
            w_ptr_nxt = r_ptr - ONE;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr     <= '0;
      r_dir     <= DIR_UP;
      r_y       <= '0;
      r_y_idx   <= '0;
      r_y_valid <= 1'b0;
      r_wrap    <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_table[i] <= WIDTH'(i);
      end
    end else begin
      if (clr) begin
        r_ptr     <= '0;
        r_dir     <= DIR_UP;
        r_y_valid <= 1'b0;
        r_wrap    <= 1'b0;
      end else if (en) begin
        r_ptr     <= w_ptr_nxt;
        r_dir     <= w_dir_nxt;
        r_y       <= r_table[r_ptr];
        r_y_idx   <= r_ptr;
        r_y_valid <= 1'b1;
        r_wrap    <= w_wrap_nxt;
      end else begin
        r_y_valid <= 1'b0;
        r_wrap    <= 1'b0;
      end
      // Same-edge read above sees the old entry, giving read-before-write.
      if (wr_en && (int'(wr_addr) < DEPTH)) begin
        r_table[wr_addr] <= wr_data;
      end
    end
  end

  assign y       = r_y;
  assign y_valid = r_y_valid;
  assign y_idx   = r_y_idx;
  assign wrap    = r_wrap;

endmodule
